// File: rtl/uart_pkg.sv
// Shared UART definitions: 2-bit frame state encoding and bit-period derivation.
// Intended for reuse by both the transmitter and a future receiver.
package uart_pkg;

  // Frame state: IDLE, START, DATA, STOP.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  // Clock cycles per serial bit; integer division truncates (27 MHz / 115200 -> 234).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit tick counter for the UART transmitter.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous active-high reset
//   restart - hold the counter at 0 (asserted while the transmitter is idle)
//   tick    - high during the last cycle of a bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  // Reloads to 0 on each bit boundary, so it never wraps inside a bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from an upstream FIFO: pops one word per frame and sends it
// as 8N1 (start, DATA_WIDTH bits LSB first, stop), idle high.
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-high reset
//   fifo_empty   - upstream FIFO has no entries
//   fifo_data    - FIFO head word, valid while fifo_empty is low
//   fifo_read_en - registered one-cycle pop request (FIFO pops on its rising edge)
//   tx           - registered serial output
//   busy         - a frame is in progress
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  read_en_q, read_en_d;
  logic                  armed_q;
  logic                  bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock  (clock),
    .reset  (reset),
    .restart(state_q == StIdle),
    .tick   (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    read_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        // armed_q keeps the first pop off the first edge after reset release, so the
        // FIFO edge detector sees fifo_read_en low before its first rising edge.
        if (armed_q && !fifo_empty) begin
          shift_d   = fifo_data;
          idx_d     = '0;
          read_en_d = 1'b1;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (idx_q == IdxLast) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      read_en_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      read_en_q <= read_en_d;
      armed_q   <= 1'b1;
    end
  end

  assign fifo_read_en = read_en_q;
  assign tx           = tx_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a 4-clocks-per-bit instance (optionally fed by a
// 16-deep FIFO model that pops on the rising edge of fifo_read_en) and a
// default-parameter instance for the 234-cycle bit period.
module tb_fifo_uart_tx;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  // Stimulus for the small instance.
  logic       tb_empty = 1'b1;
  logic [7:0] tb_data  = 8'h00;
  logic       use_fifo = 1'b0;

  logic       dut_empty;
  logic [7:0] dut_data;
  logic       read_en, tx, busy;

  // Default-parameter instance.
  logic       def_empty = 1'b1;
  logic [7:0] def_data  = 8'h00;
  logic       def_read_en, def_tx, def_busy;

  // Upstream FIFO model.
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fmem [16];
  logic [3:0] wptr, rptr;
  logic [4:0] fcount;
  logic       re_prev;
  int         pop_count;
  logic       fpop, fpush;

  assign fpop  = read_en && !re_prev && (fcount != 5'd0);
  assign fpush = wr_en && (fcount != 5'd16);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr      <= 4'd0;
      rptr      <= 4'd0;
      fcount    <= 5'd0;
      re_prev   <= 1'b0;
      pop_count <= 0;
    end else begin
      re_prev <= read_en;
      if (fpush) begin
        fmem[wptr] <= wr_data;
        wptr       <= wptr + 4'd1;
      end
      if (fpop) begin
        rptr      <= rptr + 4'd1;
        pop_count <= pop_count + 1;
      end
      fcount <= fcount + 5'(fpush) - 5'(fpop);
    end
  end

  assign dut_empty = use_fifo ? (fcount == 5'd0) : tb_empty;
  assign dut_data  = use_fifo ? fmem[rptr] : tb_data;

  fifo_uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD      (250),
    .DATA_WIDTH(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo_empty  (dut_empty),
    .fifo_data   (dut_data),
    .fifo_read_en(read_en),
    .tx          (tx),
    .busy        (busy)
  );

  fifo_uart_tx dut_def (
    .clock       (clock),
    .reset       (reset),
    .fifo_empty  (def_empty),
    .fifo_data   (def_data),
    .fifo_read_en(def_read_en),
    .tx          (def_tx),
    .busy        (def_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the pop edge; walks the 40-cycle frame and ends at the
  // STOP-to-IDLE edge.
  task automatic check_frame(input logic [7:0] w, input string tag);
    logic [9:0] frame;
    int tx_bad = 0;
    int busy_n = 0;
    int pulses = 0;
    frame = {1'b1, w, 1'b0};
    for (int i = 0; i < 40; i++) begin
      if (tx !== frame[i/4]) tx_bad++;
      if (busy === 1'b1) busy_n++;
      if (read_en === 1'b1) pulses++;
      step();
    end
    check({tag, " tx bit errors"}, tx_bad, 0);
    check({tag, " busy cycles"}, busy_n, 40);
    check({tag, " pop pulses"}, pulses, 1);
    check({tag, " idle tx"}, {31'd0, tx}, 1);
    check({tag, " idle busy"}, {31'd0, busy}, 0);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (read_en !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    int tx_bad;
    int low_n;
    int busy_n;
    logic seen_one;

    // Reset state, observed without any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset tx", {31'd0, tx}, 1);
    check("reset read_en", {31'd0, read_en}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset def tx", {31'd0, def_tx}, 1);
    repeat (3) step();
    reset = 1'b0;

    // Empty FIFO for 1000 cycles.
    pulses = 0;
    tx_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (read_en !== 1'b0) pulses++;
      if (tx !== 1'b1) tx_bad++;
    end
    check("idle pulses", pulses, 0);
    check("idle tx not high", tx_bad, 0);

    // Single word 0xA5: tx 0,1,0,1,0,0,1,0,1,1.
    tb_data  = 8'hA5;
    tb_empty = 1'b0;
    step();
    check("a5 pop", {31'd0, read_en}, 1);
    tb_empty = 1'b1;
    check_frame(8'hA5, "a5");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_en !== 1'b0) pulses++;
      step();
    end
    check("a5 no extra pop", pulses, 0);

    // 0x00 then 0xFF back to back; upstream word changes mid-frame.
    tb_data  = 8'h00;
    tb_empty = 1'b0;
    step();
    tb_data = 8'hFF;
    check_frame(8'h00, "b2b 00");
    wait_pulse(n);
    check("b2b pulse spacing", 40 + n, 41);
    check("b2b second start", {31'd0, tx}, 0);
    tb_empty = 1'b1;
    check_frame(8'hFF, "b2b ff");

    // Reset during DATA bit 3 of 0x3C (cycles 16..19 of the frame).
    tb_data  = 8'h3C;
    tb_empty = 1'b0;
    step();
    tb_data = 8'h96;
    repeat (17) step();
    check("3c bit3 tx", {31'd0, tx}, 1);
    check("3c busy", {31'd0, busy}, 1);
    #2 reset = 1'b1;
    #1;
    check("mid reset tx", {31'd0, tx}, 1);
    check("mid reset read_en", {31'd0, read_en}, 0);
    check("mid reset busy", {31'd0, busy}, 0);
    step();
    reset = 1'b0;
    step();
    check("release edge1 read_en", {31'd0, read_en}, 0);
    check("release edge1 busy", {31'd0, busy}, 0);
    step();
    check("release edge2 read_en", {31'd0, read_en}, 1);
    tb_empty = 1'b1;
    check_frame(8'h96, "post reset");

    // FIFO integration: preload three words, then hand the FIFO to the DUT.
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = words[i];
      step();
    end
    wr_en = 1'b0;
    check("fifo preload count", {27'd0, fcount}, 3);
    use_fifo = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_pulse(n);
      check("fifo pop seen", {31'd0, read_en}, 1);
      check_frame(words[j], $sformatf("fifo word%0d", j));
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (read_en !== 1'b0) pulses++;
    end
    check("fifo no extra pulse", pulses, 0);
    check("fifo empty after", {27'd0, fcount}, 0);
    check("fifo pop count", pop_count, 3);
    use_fifo = 1'b0;

    // Default parameters: 234-cycle bits, 2340-cycle frame. 0x01 gives a lone start-bit low.
    def_data  = 8'h01;
    def_empty = 1'b0;
    step();
    check("def pop", {31'd0, def_read_en}, 1);
    def_empty = 1'b1;
    low_n    = 0;
    busy_n   = 0;
    seen_one = 1'b0;
    n        = 0;
    while (def_busy === 1'b1 && n < 3000) begin
      if (!seen_one) begin
        if (def_tx === 1'b0) low_n++;
        else seen_one = 1'b1;
      end
      busy_n++;
      step();
      n++;
    end
    check("def bit period", low_n, 234);
    check("def frame length", busy_n, 2340);
    check("def idle tx", {31'd0, def_tx}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 27000000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning serial bit rate in bit/s.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-004 The block SHALL have port clock  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port fifo_empty  input  1  meaning the upstream FIFO has no entries.
REQ-007 The block SHALL have port fifo_data  input  DATA_WIDTH  meaning the FIFO head word, valid combinationally while fifo_empty is low.
REQ-008 The block SHALL have port fifo_read_en  output  1  meaning the registered pop request; the FIFO pops on its rising edge only.
REQ-009 The block SHALL have port tx  output  1  meaning the registered serial line, 8N1 framing, idle high.
REQ-010 The block SHALL have port busy  output  1  meaning a frame is in progress (state not IDLE).

Function
REQ-011 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD using integer division (234 at the defaults), and CLKS_PER_BIT < 2 SHALL be a elaboration error.
REQ-012 The state machine SHALL have the states IDLE, START, DATA and STOP.
REQ-013 In IDLE with fifo_empty low, the next edge SHALL load fifo_data into the shift register, set fifo_read_en=1, set tx=0, and go to START.
REQ-014 fifo_read_en SHALL be high for exactly one cycle per frame, and SHALL be low for at least CLKS_PER_BIT cycles between pulses, which guarantees a fresh rising edge for the FIFO edge detector.
REQ-015 In IDLE with fifo_empty high, the block SHALL stay in IDLE with tx=1 and fifo_read_en=0.
REQ-016 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL shift out DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles, using a $clog2(DATA_WIDTH)-bit index that ends at DATA_WIDTH-1.
REQ-018 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 The frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles, and back-to-back frames SHALL be separated by exactly 1 extra idle cycle, the IDLE sample.
REQ-020 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reload to 0 at each bit boundary, and never wrap mid-bit.
REQ-021 The latency from fifo_empty falling, as sampled at edge E, SHALL be that tx falls and fifo_read_en rises at edge E.
REQ-022 fifo_empty and fifo_data SHALL be ignored outside IDLE, and a latched word SHALL be immune to upstream changes.
REQ-023 busy SHALL be high from the START entry edge until the STOP-to-IDLE edge.

Reset
REQ-024 Reset SHALL immediately force state=IDLE, tx=1, fifo_read_en=0, busy=0, and all counters and the shift register to 0, without waiting for a clock edge.
REQ-025 Reset mid-frame SHALL abort the frame with no further pop; the aborted word is lost, since the upstream FIFO is reset by the same signal.
REQ-026 After reset release, the first pop SHALL occur no earlier than the second edge, giving fifo_read_en a low cycle after the FIFO edge detector comes out of reset.

Structure
REQ-027 The state encodings (2 bits) and the CLKS_PER_BIT derivation SHALL live in the shared package uart_pkg for reuse by a future receiver.
REQ-028 A single sub-module, uart_baud_gen, SHALL provide the per-bit tick counter (restart input, tick output).
REQ-029 The state machine, the shift register and the pop logic SHALL remain in fifo_uart_tx.

Verification (CLK_FREQ=1000, BAUD=250 giving CLKS_PER_BIT=4, unless stated)
REQ-030 The bench SHALL cover: reset asserted mid-cycle -> tx=1, fifo_read_en=0, busy=0 before the next edge; fifo_empty=1 for 1000 cycles -> no pulse, tx constant 1.
REQ-031 The bench SHALL cover: single word 0xA5 -> one 1-cycle fifo_read_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles, 40 cycles total; busy high for 40 cycles.
REQ-032 The bench SHALL cover: words 0x00 then 0xFF queued -> pulses 41 cycles apart; second start bit begins 1 cycle after the first stop bit ends.
REQ-033 The bench SHALL cover: reset pulsed during DATA bit 3 of 0x3C -> tx high at once; after release with fifo_empty=0, the next pulse comes no earlier than the second edge; the new frame is complete and correct.
REQ-034 The bench SHALL cover: integration with the upstream FIFO (DEPTH=16), writing 0x11, 0x22, 0x33 -> three frames in that order; FIFO empty afterwards; exactly 3 pops, no double-pop.
REQ-035 The bench SHALL cover: defaults (27 MHz, 115200 baud) -> bit period exactly 234 cycles, frame 2340 cycles.
